// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types, constants and forwarding helper for the hazard controller
package hazard_ctrl_pkg;
   typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
   typedef enum logic {IDLE, BUSY} mc_state_t;
   localparam logic [4:0] REG_X0 = 5'd0;
   function automatic fwd_sel_t fwd_sel(input logic [4:0] rs, rd_m, rd_w, input logic wr_m, wr_w);
      return (wr_m && rd_m != REG_X0 && rd_m == rs) ? FWD_M :
             (wr_w && rd_w != REG_X0 && rd_w == rs) ? FWD_W : FWD_RF;
   endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signals of the hazard controller
interface hazard_ctrl_if #(parameter int PERF_W = 32);
   logic [4:0]        rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic              reg_wrM, reg_wrW, result_srcE0, PC_srcE, mc_opE;
   logic [1:0]        fwdAE, fwdBE;
   logic              stallF, stallD, stallE, flushD, flushE, flushM, mc_busy, mc_done;
   logic [PERF_W-1:0] stall_cnt;
   modport master (
      output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, reg_wrM, reg_wrW, result_srcE0, PC_srcE, mc_opE,
      input  fwdAE, fwdBE, stallF, stallD, stallE, flushD, flushE, flushM, mc_busy, mc_done, stall_cnt
   );
   modport slave (
      input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, reg_wrM, reg_wrW, result_srcE0, PC_srcE, mc_opE,
      output fwdAE, fwdBE, stallF, stallD, stallE, flushD, flushE, flushM, mc_busy, mc_done, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl_mc_seq.sv
// hazard_ctrl_mc_seq: holds a multi-cycle Execute op for MC_LAT cycles
module hazard_ctrl_mc_seq
   import hazard_ctrl_pkg::*;
#(
   parameter int MC_LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_mc_op,
   output logic o_mc_stall,
   output logic o_mc_done
);
   localparam int CW = ($clog2(MC_LAT) < 1) ? 1 : $clog2(MC_LAT);
   mc_state_t r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   // state and remaining-stall counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end
   // first op cycle is seen in IDLE, so BUSY only covers the remaining MC_LAT-2 stalls plus the done cycle
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_mc_stall  = 1'b0;
      o_mc_done   = 1'b0;
      if (r_state == IDLE) begin
         if (i_mc_op && MC_LAT > 1) begin
            o_mc_stall  = 1'b1;
            w_state_nxt = BUSY;
            w_cnt_nxt   = CW'(MC_LAT - 2);
         end else begin
            o_mc_done = i_mc_op && MC_LAT == 1;
         end
      end else if (r_cnt != '0) begin
         o_mc_stall = 1'b1;
         w_cnt_nxt  = r_cnt - CW'(1);
      end else begin
         o_mc_done   = 1'b1;
         w_state_nxt = IDLE;
      end
   end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use/branch/multi-cycle stall and flush control with a stall counter
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MC_LAT = 4,
   parameter int PERF_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);
   fwd_sel_t          w_fwd_a, w_fwd_b;
   logic              w_lw_stall, w_mc_stall, w_mc_done, w_stall_f;
   logic [PERF_W-1:0] r_stall_cnt;

   hazard_ctrl_mc_seq #(.MC_LAT(MC_LAT)) u_mc_seq (
      .clk       (clk),
      .rst       (rst),
      .i_mc_op   (hz.mc_opE),
      .o_mc_stall(w_mc_stall),
      .o_mc_done (w_mc_done)
   );

   assign w_fwd_a    = fwd_sel(hz.rs1E, hz.rdM, hz.rdW, hz.reg_wrM, hz.reg_wrW);
   assign w_fwd_b    = fwd_sel(hz.rs2E, hz.rdM, hz.rdW, hz.reg_wrM, hz.reg_wrW);
   assign w_lw_stall = hz.result_srcE0 && hz.rdE != REG_X0 && (hz.rdE == hz.rs1D || hz.rdE == hz.rs2D);
   assign w_stall_f  = w_lw_stall || w_mc_stall;

   assign hz.fwdAE     = w_fwd_a;
   assign hz.fwdBE     = w_fwd_b;
   assign hz.stallF    = !rst && w_stall_f;
   assign hz.stallD    = !rst && w_stall_f;
   assign hz.stallE    = !rst && w_mc_stall;
   assign hz.flushM    = !rst && w_mc_stall;
   assign hz.mc_busy   = !rst && w_mc_stall;
   assign hz.mc_done   = !rst && w_mc_done;
   assign hz.flushD    = !rst && hz.PC_srcE && !w_mc_stall;
   assign hz.flushE    = !rst && (w_lw_stall || hz.PC_srcE) && !w_mc_stall;
   assign hz.stall_cnt = r_stall_cnt;

   // saturating count of fetch-stall cycles
   always_ff @(posedge clk) begin
      if (rst) r_stall_cnt <= '0;
      else if (w_stall_f && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + PERF_W'(1);
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table, directed and random checks of hazard_ctrl against a cycle-level model
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic       reg_wrM, reg_wrW, ld, pc, mc;

   hazard_ctrl_if #(.PERF_W(4)) ifa ();
   hazard_ctrl_if #(.PERF_W(8)) ifb ();

   assign ifa.rs1D = rs1D;  assign ifa.rs2D = rs2D;  assign ifa.rs1E = rs1E;  assign ifa.rs2E = rs2E;
   assign ifa.rdE = rdE;    assign ifa.rdM = rdM;    assign ifa.rdW = rdW;
   assign ifa.reg_wrM = reg_wrM;  assign ifa.reg_wrW = reg_wrW;
   assign ifa.result_srcE0 = ld;  assign ifa.PC_srcE = pc;  assign ifa.mc_opE = mc;
   assign ifb.rs1D = rs1D;  assign ifb.rs2D = rs2D;  assign ifb.rs1E = rs1E;  assign ifb.rs2E = rs2E;
   assign ifb.rdE = rdE;    assign ifb.rdM = rdM;    assign ifb.rdW = rdW;
   assign ifb.reg_wrM = reg_wrM;  assign ifb.reg_wrW = reg_wrW;
   assign ifb.result_srcE0 = ld;  assign ifb.PC_srcE = pc;  assign ifb.mc_opE = mc;

   hazard_ctrl #(.MC_LAT(4), .PERF_W(4)) dut_a (.clk(clk), .rst(rst), .hz(ifa.slave));
   hazard_ctrl #(.MC_LAT(1), .PERF_W(8)) dut_b (.clk(clk), .rst(rst), .hz(ifb.slave));

   typedef struct {
      logic [1:0] fa, fb;
      logic sF, sD, sE, fD, fE, fM, busy, done;
   } outs_t;

   typedef struct {
      logic [4:0] r1E, r2E, dM, dW;
      logic       wM, wW;
      logic [4:0] r1D, r2D, dE;
      logic       l, p;
      logic [1:0] fa, fb;
      logic       sF, fD, fE;
   } vec_t;

   int checks = 0, errors = 0;
   int held_a = 0, held_b = 0, cnt_a = 0, cnt_b = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (reg_wrM && rdM != 0 && rdM == rs) return 2'b10;
      if (reg_wrW && rdW != 0 && rdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   // held = cycles the current op has already spent in E; op leaves E after L cycles total
   function automatic outs_t ref_outs(input int lat, input int held);
      outs_t o;
      bit active = held > 0 || mc;
      bit mcs    = active && (held + 1) < lat;
      bit lw     = ld && rdE != 0 && (rdE == rs1D || rdE == rs2D);
      o.fa   = ref_fwd(rs1E);
      o.fb   = ref_fwd(rs2E);
      o.sF   = !rst && (lw || mcs);
      o.sD   = o.sF;
      o.sE   = !rst && mcs;
      o.fM   = o.sE;
      o.busy = o.sE;
      o.fD   = !rst && pc && !mcs;
      o.fE   = !rst && (lw || pc) && !mcs;
      o.done = !rst && active && (held + 1) == lat;
      return o;
   endfunction

   function automatic int next_held(input int lat, input int held);
      if (rst || !(held > 0 || mc)) return 0;
      return (held + 1 >= lat) ? 0 : held + 1;
   endfunction

   function automatic outs_t get_a();
      outs_t o;
      o.fa = ifa.fwdAE;   o.fb = ifa.fwdBE;   o.sF = ifa.stallF;  o.sD = ifa.stallD;  o.sE = ifa.stallE;
      o.fD = ifa.flushD;  o.fE = ifa.flushE;  o.fM = ifa.flushM;  o.busy = ifa.mc_busy; o.done = ifa.mc_done;
      return o;
   endfunction

   function automatic outs_t get_b();
      outs_t o;
      o.fa = ifb.fwdAE;   o.fb = ifb.fwdBE;   o.sF = ifb.stallF;  o.sD = ifb.stallD;  o.sE = ifb.stallE;
      o.fD = ifb.flushD;  o.fE = ifb.flushE;  o.fM = ifb.flushM;  o.busy = ifb.mc_busy; o.done = ifb.mc_done;
      return o;
   endfunction

   task automatic cmp(input string tag, input outs_t a, input outs_t e);
      chk({tag, ".fwdAE"}, 32'(a.fa), 32'(e.fa));
      chk({tag, ".fwdBE"}, 32'(a.fb), 32'(e.fb));
      chk({tag, ".stallF"}, 32'(a.sF), 32'(e.sF));
      chk({tag, ".stallD"}, 32'(a.sD), 32'(e.sD));
      chk({tag, ".stallE"}, 32'(a.sE), 32'(e.sE));
      chk({tag, ".flushD"}, 32'(a.fD), 32'(e.fD));
      chk({tag, ".flushE"}, 32'(a.fE), 32'(e.fE));
      chk({tag, ".flushM"}, 32'(a.fM), 32'(e.fM));
      chk({tag, ".mc_busy"}, 32'(a.busy), 32'(e.busy));
      chk({tag, ".mc_done"}, 32'(a.done), 32'(e.done));
   endtask

   // compare one cycle against the model, then advance across the rising edge
   task automatic step();
      outs_t ea, eb;
      int na, nb, ca, cb;
      #3;
      ea = ref_outs(4, held_a);
      eb = ref_outs(1, held_b);
      cmp("A", get_a(), ea);
      cmp("B", get_b(), eb);
      chk("A.stall_cnt", 32'(ifa.stall_cnt), 32'(cnt_a));
      chk("B.stall_cnt", 32'(ifb.stall_cnt), 32'(cnt_b));
      na = next_held(4, held_a);
      nb = next_held(1, held_b);
      ca = rst ? 0 : (ea.sF && cnt_a < 15) ? cnt_a + 1 : cnt_a;
      cb = rst ? 0 : (eb.sF && cnt_b < 255) ? cnt_b + 1 : cnt_b;
      @(posedge clk);
      held_a = na; held_b = nb; cnt_a = ca; cnt_b = cb;
      #1;
   endtask

   task automatic clr();
      {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
      {reg_wrM, reg_wrW, ld, pc, mc} = '0;
   endtask

   task automatic mc_op(input string tag);
      for (int k = 1; k <= 4; k++) begin
         mc = 1'b1;
         #2;
         chk({tag, ".stallE"}, 32'(ifa.stallE), 32'(k < 4));
         chk({tag, ".flushM"}, 32'(ifa.flushM), 32'(k < 4));
         chk({tag, ".mc_done"}, 32'(ifa.mc_done), 32'(k == 4));
         step();
      end
   endtask

   vec_t tbl[9];
   int c0;

   initial begin
      tbl[0] = '{5, 6, 5, 5, 1, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0};
      tbl[1] = '{5, 6, 5, 5, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0};
      tbl[2] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
      tbl[3] = '{3, 9, 9, 3, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0};
      tbl[4] = '{0, 0, 0, 0, 0, 0, 1, 7, 7, 1, 0, 2'b00, 2'b00, 1, 0, 1};
      tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0};
      tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1};
      tbl[7] = '{0, 0, 0, 0, 0, 0, 8, 2, 8, 1, 1, 2'b00, 2'b00, 1, 1, 1};
      tbl[8] = '{4, 31, 31, 31, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0};
      clr();
      rst = 1'b1;
      @(posedge clk); #1;
      step();
      #2;
      chk("reset.stall_cnt", 32'(ifa.stall_cnt), 32'd0);
      chk("reset.stallF", 32'(ifa.stallF), 32'd0);
      rst = 1'b0;
      step();
      for (int i = 0; i < 9; i++) begin
         rs1E = tbl[i].r1E; rs2E = tbl[i].r2E; rdM = tbl[i].dM; rdW = tbl[i].dW;
         reg_wrM = tbl[i].wM; reg_wrW = tbl[i].wW; rs1D = tbl[i].r1D; rs2D = tbl[i].r2D;
         rdE = tbl[i].dE; ld = tbl[i].l; pc = tbl[i].p;
         #2;
         chk($sformatf("tbl%0d.fwdAE", i), 32'(ifa.fwdAE), 32'(tbl[i].fa));
         chk($sformatf("tbl%0d.fwdBE", i), 32'(ifa.fwdBE), 32'(tbl[i].fb));
         chk($sformatf("tbl%0d.stallF", i), 32'(ifa.stallF), 32'(tbl[i].sF));
         chk($sformatf("tbl%0d.stallE", i), 32'(ifa.stallE), 32'd0);
         chk($sformatf("tbl%0d.flushD", i), 32'(ifa.flushD), 32'(tbl[i].fD));
         chk($sformatf("tbl%0d.flushE", i), 32'(ifa.flushE), 32'(tbl[i].fE));
         step();
      end
      clr();
      chk("tbl.stall_cnt", 32'(ifa.stall_cnt), 32'd2);
      c0 = int'(ifa.stall_cnt);
      mc_op("mc1");
      mc_op("mc2");
      mc = 1'b0;
      #2;
      chk("mc.stall_cnt", 32'(ifa.stall_cnt), 32'(c0 + 6));
      step();
      mc = 1'b1;
      step();
      pc = 1'b1; ld = 1'b1; rdE = 7; rs2D = 7;
      #2;
      chk("prio.flushD", 32'(ifa.flushD), 32'd0);
      chk("prio.flushE", 32'(ifa.flushE), 32'd0);
      chk("prio.stallE", 32'(ifa.stallE), 32'd1);
      step();
      clr(); mc = 1'b1;
      step();
      step();
      mc = 1'b0;
      ld = 1'b1; rdE = 7; rs2D = 7;
      for (int i = 0; i < 16; i++) step();
      #2;
      chk("sat.stall_cnt", 32'(ifa.stall_cnt), 32'd15);
      clr();
      step();
      mc = 1'b1;
      step();
      rst = 1'b1;
      #2;
      chk("rst.stallF", 32'(ifa.stallF), 32'd0);
      chk("rst.mc_busy", 32'(ifa.mc_busy), 32'd0);
      step();
      rst = 1'b0;
      #2;
      chk("rst.cnt_cleared", 32'(ifa.stall_cnt), 32'd0);
      step();
      for (int k = 0; k < 3; k++) step();
      c0 = int'(ifa.stall_cnt);
      mc_op("fresh");
      mc = 1'b0;
      #2;
      chk("fresh.stall_cnt", 32'(ifa.stall_cnt), 32'(c0 + 3));
      step();
      for (int i = 0; i < 2000; i++) begin
         rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
         rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
         rdE = 5'($urandom_range(0, 3));  rdM = 5'($urandom_range(0, 3)); rdW = 5'($urandom_range(0, 3));
         reg_wrM = 1'($urandom); reg_wrW = 1'($urandom);
         ld = ($urandom_range(0, 3) == 0);
         pc = ($urandom_range(0, 7) == 0);
         mc = (held_a > 0) ? 1'b1 : ($urandom_range(0, 5) == 0);
         rst = ($urandom_range(0, 99) == 0);
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
